fp16_add_sequencer: RTL and testbench

Operand issue and result collection stage wrapped around the fp16 single-cycle adder.
- Accepts add/sub commands over a valid/ready stream.
- Turns subtraction into addition by flipping the sign of operand B, then drives the adder's i_valid/i_a/i_b.
- Captures o_res/Overflow/o_res_vld into an in-order result FIFO with a valid/ready output and a sequence tag.
- Credit-based issue: an accepted command always has a FIFO slot, so no adder result is ever lost.

---
 rtl/fp16_pkg.sv | 28 ++
 rtl/fp16_res_fifo.sv | 68 ++++++
 rtl/fp16_add_sequencer.sv | 137 +++++++++++++
 tb/tb_fp16_add_sequencer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared fp16 field layout, constants and result entry type
// for the fp16 add sequencer and its result FIFO.
package fp16_pkg;

    localparam int FP16_W    = 16;
    localparam int EXP_W     = 5;
    localparam int MAN_W     = 10;
    localparam int SIGN_BIT  = 15;
    localparam int SEQ_TAG_W = 4;

    localparam logic [FP16_W-1:0] FP16_INF = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_ONE = 16'h3C00;

    typedef struct packed {
        logic                 ovf;
        logic [SEQ_TAG_W-1:0] tag;
        logic [FP16_W-1:0]    res;
    } res_entry_t;

    // A-B is issued as A+(-B): only the sign bit of B changes.
    function automatic logic [FP16_W-1:0] fp16_cond_neg(
        input logic [FP16_W-1:0] x,
        input logic              neg
    );
        return {x[SIGN_BIT] ^ neg, x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/fp16_res_fifo.sv
// fp16_res_fifo: in-order synchronous result FIFO with occupancy count.
// Storage is register based so the head entry is visible without latency.
module fp16_res_fifo
    import fp16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 21,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [W-1:0]     o_data,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            if (i_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!(i_push && !w_pop && w_full));
        end
    end

    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fp16_add_sequencer.sv
// fp16_add_sequencer: issues add/sub commands to an external single-cycle
// fp16 adder and returns tagged results in order through a credited FIFO.
module fp16_add_sequencer
    import fp16_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = SEQ_TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FP16_W-1:0] s_a,
    input  logic [FP16_W-1:0] s_b,
    input  logic              s_sub,
    output logic              add_valid,
    output logic [FP16_W-1:0] add_a,
    output logic [FP16_W-1:0] add_b,
    input  logic [FP16_W-1:0] add_res,
    input  logic              add_ovf,
    input  logic              add_vld,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FP16_W-1:0] m_res,
    output logic              m_ovf,
    output logic [TAG_W-1:0]  m_tag,
    output logic              err_orphan
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int ENT_W = 1 + TAG_W + FP16_W;

    logic              r_s_ready;
    logic              r_add_valid;
    logic [FP16_W-1:0] r_add_a;
    logic [FP16_W-1:0] r_add_b;
    logic [1:0]        r_pend;
    logic [TAG_W-1:0]  r_iss_tag;
    logic [TAG_W-1:0]  r_wr_tag;
    logic              r_err;

    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_vld;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [1:0]        w_pend_nxt;
    logic [SUM_W-1:0]  w_used_nxt;
    logic [ENT_W-1:0]  w_wr_ent;
    logic [ENT_W-1:0]  w_rd_ent;

    assign w_accept = s_valid & r_s_ready;
    assign w_push   = add_vld & (r_pend != 2'd0);
    assign w_pop    = w_fifo_vld & m_ready;

    always_comb begin
        w_pend_nxt  = r_pend;
        w_count_nxt = w_count;
        if (w_accept && !w_push) begin
            w_pend_nxt = r_pend + 2'd1;
        end else if (!w_accept && w_push) begin
            w_pend_nxt = r_pend - 2'd1;
        end
        if (w_push && !w_pop) begin
            w_count_nxt = w_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = w_count - CNT_W'(1);
        end
    end

    // Credits count both stored results and those still in the adder pipe.
    assign w_used_nxt = SUM_W'(w_count_nxt) + SUM_W'(w_pend_nxt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s_ready   <= 1'b0;
            r_add_valid <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_pend      <= 2'd0;
            r_iss_tag   <= '0;
            r_wr_tag    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_s_ready   <= (w_used_nxt < SUM_W'(DEPTH));
            r_add_valid <= w_accept;
            r_pend      <= w_pend_nxt;
            if (w_accept) begin
                r_add_a   <= s_a;
                r_add_b   <= fp16_cond_neg(s_b, s_sub);
                r_iss_tag <= r_iss_tag + TAG_W'(1);
            end
            if (w_push) begin
                r_wr_tag <= r_wr_tag + TAG_W'(1);
            end
            if (add_vld && r_pend == 2'd0) begin
                r_err <= 1'b1;
            end
        end
    end

    // Every issued tag not yet written must still be pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (TAG_W'(r_iss_tag - r_wr_tag) == TAG_W'(r_pend));
            assert (r_pend != 2'd3);
        end
    end

    assign w_wr_ent = {add_ovf, r_wr_tag, add_res};

    fp16_res_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_wr_ent),
        .i_pop   (w_pop),
        .o_valid (w_fifo_vld),
        .o_data  (w_rd_ent),
        .o_count (w_count)
    );

    assign s_ready    = r_s_ready;
    assign add_valid  = r_add_valid;
    assign add_a      = r_add_a;
    assign add_b      = r_add_b;
    assign m_valid    = w_fifo_vld;
    assign {m_ovf, m_tag, m_res} = w_rd_ent;
    assign err_orphan = r_err;

endmodule

// File: tb/tb_fp16_add_sequencer.sv
// tb_fp16_add_sequencer: directed checks of issue, latency, credits,
// ordering, tag wrap, reset and orphan detection with a stand-in adder.
module tb_fp16_add_sequencer;
    import fp16_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_a = '0;
    logic [15:0] s_b = '0;
    logic        s_sub = 1'b0;
    logic        add_valid;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_res;
    logic        add_ovf;
    logic        add_vld;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_res;
    logic        m_ovf;
    logic [3:0]  m_tag;
    logic        err_orphan;

    logic        r_vld;
    logic        force_vld = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fp16_add_sequencer #(.DEPTH(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_a        (s_a),
        .s_b        (s_b),
        .s_sub      (s_sub),
        .add_valid  (add_valid),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_res    (add_res),
        .add_ovf    (add_ovf),
        .add_vld    (add_vld),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_res      (m_res),
        .m_ovf      (m_ovf),
        .m_tag      (m_tag),
        .err_orphan (err_orphan)
    );

    // Stand-in adder: exact fp16 sums for the directed vectors, an
    // arbitrary deterministic mix otherwise (results are only passed through).
    function automatic logic [16:0] adder_model(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            {FP16_ONE, 16'h4000}:  return {1'b0, 16'h4200};
            {16'h4200, 16'hBC00}:  return {1'b0, 16'h4000};
            {16'h7BFF, 16'h7BFF}:  return {1'b1, FP16_INF};
            default:               return {a[0] & b[0], a ^ {b[7:0], b[15:8]}};
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld   <= 1'b0;
            add_res <= '0;
            add_ovf <= 1'b0;
        end else begin
            r_vld <= add_valid;
            if (add_valid) begin
                {add_ovf, add_res} <= adder_model(add_a, add_b);
            end
        end
    end

    assign add_vld = r_vld | force_vld;

    task automatic do_reset();
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        force_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub);
        int  n;
        logic acc;
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        s_sub = sub;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = s_ready;
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout got s_ready=0 for %0d cycles exp accept", n);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({s_ready, add_valid, m_valid, m_ovf, err_orphan} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {s_ready, add_valid, m_valid, m_ovf, err_orphan});
        end
        n_checks++;
        if ({add_a, add_b, m_res, m_tag} !== 52'h0) begin
            n_errors++;
            $display("FAIL reset_data got %h exp 0", {add_a, add_b, m_res, m_tag});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready got %b exp 1", s_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vs [3];
        logic [15:0] eb [3];
        logic [15:0] er [3];
        logic        eo [3];
        va = '{16'h3C00, 16'h4200, 16'h7BFF};
        vb = '{16'h4000, 16'h3C00, 16'h7BFF};
        vs = '{1'b0, 1'b1, 1'b0};
        eb = '{16'h4000, 16'hBC00, 16'h7BFF};
        er = '{16'h4200, 16'h4000, 16'h7C00};
        eo = '{1'b0, 1'b0, 1'b1};
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], vs[i]);
            n_checks++;
            if ({add_valid, add_a, add_b} !== {1'b1, va[i], eb[i]}) begin
                n_errors++;
                $display("FAIL issue_%0d got v=%b a=%h b=%h exp v=1 a=%h b=%h",
                         i, add_valid, add_a, add_b, va[i], eb[i]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({add_valid, add_b, m_valid} !== {1'b0, eb[i], 1'b0}) begin
                n_errors++;
                $display("FAIL hold_%0d got v=%b b=%h mv=%b exp v=0 b=%h mv=0",
                         i, add_valid, add_b, m_valid, eb[i]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if ({m_valid, m_res, m_ovf, m_tag} !== {1'b1, er[i], eo[i], 4'(i)}) begin
                n_errors++;
                $display("FAIL result_%0d got v=%b r=%h o=%b t=%0d exp v=1 r=%h o=%b t=%0d",
                         i, m_valid, m_res, m_ovf, m_tag, er[i], eo[i], i);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (m_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL popped_%0d got m_valid=%b exp 0", i, m_valid);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_full();
        res_entry_t  exp_q[$];
        res_entry_t  e;
        int          nacc;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        acc;
        nacc = 0;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 16'h1000 + 16'(nacc * 273);
            b = 16'h2000 + 16'(nacc * 5);
            sub = nacc[0];
            s_valid = 1'b1;
            s_a = a;
            s_b = b;
            s_sub = sub;
            acc = s_ready;
            if (acc) begin
                {e.ovf, e.res} = adder_model(a, {b[15] ^ sub, b[14:0]});
                e.tag = 4'(nacc);
                exp_q.push_back(e);
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        n_checks++;
        if (nacc !== 4) begin
            n_errors++;
            $display("FAIL full_accepts got %0d exp 4", nacc);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({s_ready, m_valid} !== 2'b01) begin
            n_errors++;
            $display("FAIL full_state got ready=%b valid=%b exp ready=0 valid=1", s_ready, m_valid);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            n_checks++;
            if ({m_valid, m_ovf, m_tag, m_res} !== {1'b1, e}) begin
                n_errors++;
                $display("FAIL drain_%0d got v=%b o=%b t=%0d r=%h exp v=1 o=%b t=%0d r=%h",
                         k, m_valid, m_ovf, m_tag, m_res, e.ovf, e.tag, e.res);
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                n_checks++;
                if (s_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ready_after_pop got %b exp 1", s_ready);
                end
            end
        end
        n_checks++;
        if (m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty got m_valid=%b exp 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        res_entry_t  exp_q[$];
        res_entry_t  e;
        int          idx;
        int          popped;
        int          cyc;
        logic [3:0]  exp_tag;
        logic [3:0]  prev_tag;
        logic        wrapped;
        logic        acc;
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        idx = 0;
        popped = 0;
        cyc = 0;
        exp_tag = 4'd0;
        prev_tag = 4'd0;
        wrapped = 1'b0;
        while ((idx < 20 || exp_q.size() != 0) && cyc < 400) begin
            m_ready = ($urandom_range(0, 3) != 0);
            a = 16'h0031 + 16'(idx * 256);
            b = 16'h8421 ^ 16'(idx * 7);
            sub = (idx % 3 == 0);
            s_valid = (idx < 20);
            s_a = a;
            s_b = b;
            s_sub = sub;
            acc = s_valid && s_ready;
            if (m_valid && m_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL b2b_extra got tag=%0d res=%h exp no result", m_tag, m_res);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_ovf, m_tag, m_res} !== e) begin
                        n_errors++;
                        $display("FAIL b2b_entry_%0d got o=%b t=%0d r=%h exp o=%b t=%0d r=%h",
                                 popped, m_ovf, m_tag, m_res, e.ovf, e.tag, e.res);
                    end
                    if (popped > 0 && prev_tag == 4'd15 && m_tag == 4'd0) begin
                        wrapped = 1'b1;
                    end
                    prev_tag = m_tag;
                    popped++;
                end
            end
            if (acc) begin
                {e.ovf, e.res} = adder_model(a, {b[15] ^ sub, b[14:0]});
                e.tag = exp_tag;
                exp_q.push_back(e);
                exp_tag = exp_tag + 4'd1;
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        n_checks++;
        if (popped !== 20) begin
            n_errors++;
            $display("FAIL b2b_count got %0d exp 20 (cycles %0d)", popped, cyc);
        end
        n_checks++;
        if (wrapped !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_tag_wrap got %b exp 1", wrapped);
        end
        n_checks++;
        if (err_orphan !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_orphan got %b exp 0", err_orphan);
        end
    endtask

    task automatic test_reset_inflight();
        m_ready = 1'b0;
        send(16'h1234, 16'h0101, 1'b0);
        send(16'h2345, 16'h0202, 1'b1);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({s_ready, add_valid, m_valid, m_ovf, err_orphan} !== 5'b0) begin
            n_errors++;
            $display("FAIL midreset_flags got %b exp 00000",
                     {s_ready, add_valid, m_valid, m_ovf, err_orphan});
        end
        n_checks++;
        if ({add_a, add_b, m_res, m_tag} !== 52'h0) begin
            n_errors++;
            $display("FAIL midreset_data got %h exp 0", {add_a, add_b, m_res, m_tag});
        end
        @(posedge clk);
        #1 rst = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({m_valid, err_orphan} !== 2'b00) begin
            n_errors++;
            $display("FAIL midreset_discard got valid=%b orphan=%b exp 0 0", m_valid, err_orphan);
        end
        send(FP16_ONE, 16'h4000, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({m_valid, m_tag, m_res} !== {1'b1, 4'd0, 16'h4200}) begin
            n_errors++;
            $display("FAIL post_reset_tag got v=%b t=%0d r=%h exp v=1 t=0 r=4200",
                     m_valid, m_tag, m_res);
        end
        @(posedge clk);
        #1;
        force_vld = 1'b1;
        @(posedge clk);
        #1;
        force_vld = 1'b0;
        n_checks++;
        if ({err_orphan, m_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL orphan_set got orphan=%b valid=%b exp 1 0", err_orphan, m_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (err_orphan !== 1'b1) begin
            n_errors++;
            $display("FAIL orphan_sticky got %b exp 1", err_orphan);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        @(posedge clk);
        test_reset();
        test_directed();
        do_reset();
        test_full();
        do_reset();
        test_back_to_back();
        do_reset();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
